s1_wb_slave_sequencer: RTL

//  Single-master Wishbone address decoder and transaction sequencer between s1_top and NSLV memory harnesses.

---
 rtl/s1_wb_slave_sequencer_if.sv | 25 ++
 rtl/s1_wb_slave_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/s1_wb_slave_sequencer_if.sv
// Wishbone bundle between the single master, the sequencer and its NSLV slave harnesses.
// The slave modport is the sequencer's view; the master modport is the opposite side (core plus slave models).
interface s1_wb_slave_sequencer_if #(
   parameter int NSLV = 8
);
   logic                 wbm_cycle_i;
   logic                 wbm_strobe_i;
   logic [39:0]          wbm_addr_i;
   logic                 wbm_ack_o;
   logic [63:0]          wbm_data_o;
   logic [NSLV-1:0]      wbs_cycle_o;
   logic [NSLV-1:0]      wbs_strobe_o;
   logic [NSLV-1:0]      wbs_ack_i;
   logic [NSLV*64-1:0]   wbs_data_i;

   modport slave (
      input  wbm_cycle_i, wbm_strobe_i, wbm_addr_i, wbs_ack_i, wbs_data_i,
      output wbm_ack_o, wbm_data_o, wbs_cycle_o, wbs_strobe_o
   );

   modport master (
      output wbm_cycle_i, wbm_strobe_i, wbm_addr_i, wbs_ack_i, wbs_data_i,
      input  wbm_ack_o, wbm_data_o, wbs_cycle_o, wbs_strobe_o
   );
endinterface

// File: rtl/s1_wb_slave_sequencer.sv
// Single-master Wishbone decoder/sequencer: one-hot slave select, timeout and unmapped termination.
// Optional error capture registers enabled by defining S1_WB_ERR_CAPTURE_EN.
module s1_wb_slave_sequencer #(
   parameter int               NSLV           = 8,
   parameter logic [NSLV*40-1:0] REGION_BASE  = {NSLV{40'h0}},
   parameter logic [NSLV*40-1:0] REGION_MASK  = {NSLV{40'h0}},
   parameter int               TIMEOUT_CYCLES = 255,
   parameter logic [63:0]      DEFAULT_DATA   = 64'h0100000001000000
) (
   input  logic                              sys_clock_i,
   input  logic                              sys_reset_i,
   s1_wb_slave_sequencer_if.slave            bus,
   output logic                              err_valid_o,
   output logic [39:0]                       err_addr_o,
   input  logic                              err_clear_i
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;
   localparam logic [1:0] ST_TOUT = 2'd3;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]      state, state_n;
   logic [NSLV-1:0] sel, hit, hit_lo;
   logic [7:0]      cnt;
   logic [63:0]     dmux;
   logic            req, busy, synth, slv_ack;

   assign req   = bus.wbm_cycle_i & bus.wbm_strobe_i;
   assign busy  = (state == ST_BUSY);
   assign synth = (state == ST_ERR) | (state == ST_TOUT);

   always_comb begin
      hit = '0;
      for (int i = 0; i < NSLV; i++)
         hit[i] = ((bus.wbm_addr_i & REGION_MASK[40*i +: 40]) == REGION_BASE[40*i +: 40]);
   end

   // Overlapping regions: the lowest index wins.
   always_comb begin
      hit_lo = '0;
      for (int i = NSLV-1; i >= 0; i--)
         if (hit[i]) begin
            hit_lo    = '0;
            hit_lo[i] = 1'b1;
         end
   end

   always_comb begin
      dmux = '0;
      for (int i = 0; i < NSLV; i++)
         if (sel[i]) dmux = dmux | bus.wbs_data_i[64*i +: 64];
   end

   // Ack is qualified by the master request so an aborting master never sees one.
   assign slv_ack = req & |(bus.wbs_ack_i & sel);

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (req) state_n = (|hit) ? ST_BUSY : ST_ERR;
         ST_BUSY: begin
            if (!req || slv_ack)       state_n = ST_IDLE;
            else if (cnt == TMO_LAST)  state_n = ST_TOUT;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
      if (!sys_reset_i) begin
         state <= ST_IDLE;
         sel   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE) begin
            if (req) sel <= hit_lo;
         end else if (state_n == ST_IDLE) begin
            sel <= '0;
         end
         // Zero whenever not staying in BUSY, so entry and abort both start from 0.
         if (busy && state_n == ST_BUSY)
            cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
         else
            cnt <= '0;
      end
   end

   assign bus.wbs_cycle_o  = busy ? (sel & {NSLV{req}}) : '0;
   assign bus.wbs_strobe_o = busy ? (sel & {NSLV{req}}) : '0;
   assign bus.wbm_ack_o    = (busy & slv_ack) | synth;
   assign bus.wbm_data_o   = synth ? DEFAULT_DATA : (busy ? dmux : 64'h0);

`ifdef S1_WB_ERR_CAPTURE_EN
   logic        err_v;
   logic [39:0] err_a;

   always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
      if (!sys_reset_i) begin
         err_v <= 1'b0;
         err_a <= '0;
      end else if (synth && (!err_v || err_clear_i)) begin
         err_v <= 1'b1;
         err_a <= bus.wbm_addr_i;
      end else if (err_clear_i) begin
         err_v <= 1'b0;
      end
   end

   assign err_valid_o = err_v;
   assign err_addr_o  = err_a;
`else
   logic unused_err_clear;
   assign unused_err_clear = err_clear_i;
   assign err_valid_o      = 1'b0;
   assign err_addr_o       = '0;
`endif
endmodule
